// File: rtl/cell_bist_ctrl.sv
// BIST controller for the inv/nand2/nor2/aoi21/oai21 cell set: sweeps all 8 input
// patterns, checks each response against a golden model and compacts it into a MISR.
module cell_bist_ctrl #(
  parameter int unsigned       SETTLE_CYC = 2,
  parameter int unsigned       SIG_W      = 16,
  parameter logic [SIG_W-1:0]  POLY       = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]  SEED       = SIG_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [2:0]       pat,
  input  logic [4:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [3:0]       err_cnt,
  output logic [3:0]       first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       settle_cnt;
  logic             settle_last;
  logic             a, b, c;
  logic [4:0]       golden;
  logic             mismatch;
  logic [SIG_W-1:0] misr_shift;
  logic [SIG_W-1:0] misr_next;

  assign settle_last = (settle_cnt == 4'(SETTLE_CYC - 1));

  assign {a, b, c} = pat;
  assign golden    = {~(a & (b | c)), ~(a | (b & c)), ~(a | b), ~(a & b), ~a};
  assign mismatch  = (resp != golden);

  assign misr_shift = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);
  assign misr_next  = misr_shift ^ {{(SIG_W-5){1'b0}}, resp};

  assign busy = (state_q != IDLE);
  assign done = (state_q == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = CAPTURE;
      CAPTURE: state_d = (pat == 3'd7) ? CHECK : SETTLE;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results (pass/sig/err_cnt/first_fail) are only touched on an accepted start,
  // in CAPTURE, or in CHECK, so they hold in IDLE between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat        <= '0;
      settle_cnt <= '0;
      sig        <= SEED;
      err_cnt    <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pat <= '0;
          if (start) begin
            settle_cnt <= '0;
            sig        <= SEED;
            err_cnt    <= '0;
            first_fail <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + 4'd1;
        end
        CAPTURE: begin
          sig <= misr_next;
          if (mismatch) begin
            if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
            if (!first_fail[3]) first_fail <= {1'b1, pat};
          end
          if (pat != 3'd7) pat <= pat + 3'd1;
        end
        CHECK: begin
          pass <= (err_cnt == 4'd0) && (sig == exp_sig);
          pat  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
